switch_conditioner: RTL and testbench
=====================================

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 240000, consecutive cycles a synchronized bit must differ from its stable value before the stable value updates; legal range >= 1.
REQ-002 Parameter: REPEAT_CYCLES, 0, auto-repeat interval for held push/pop buttons in cycles; 0 disables auto-repeat.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: sw_n  input  8  raw active-low switches: [3:0] data, [4] push, [5] pop, [6] reset button, [7] mode.
REQ-006 Port: data_out  output  4  debounced, active-high data nibble.
REQ-007 Port: push_pulse  output  1  one-cycle strobe per debounced push press or repeat.
REQ-008 Port: pop_pulse  output  1  one-cycle strobe per debounced pop press or repeat.
REQ-009 Port: rst_btn  output  1  debounced, active-high level of the reset button.
REQ-010 Port: mode  output  1  debounced, active-high mode level.

Function
REQ-011 Each sw_n bit SHALL be inverted, then passed through a 2-flop synchronizer before any other use.
REQ-012 Each bit SHALL have an independent counter of width clog2(DEBOUNCE_CYCLES+1) that increments while the synchronized value differs from the stable value and clears to 0 on any cycle they match.
REQ-013 The stable value SHALL toggle, and its counter clear, on the edge at which the counter would reach DEBOUNCE_CYCLES; glitches shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the stable value.
REQ-014 data_out, rst_btn and mode SHALL equal the stable values directly; latency from the raw edge is 2 + DEBOUNCE_CYCLES cycles.
REQ-015 Push and pop SHALL each use an FSM with states IDLE, HELD: IDLE->HELD on a stable 0->1 transition; HELD->IDLE on a stable 1->0 transition.
REQ-016 On IDLE->HELD the matching strobe SHALL be registered high for exactly one cycle, first high 2 + DEBOUNCE_CYCLES + 1 cycles after the raw edge.
REQ-017 In HELD with REPEAT_CYCLES > 0, a repeat counter SHALL emit a one-cycle strobe every REPEAT_CYCLES cycles after the initial strobe, with no strobe on the HELD->IDLE transition cycle.
REQ-018 In HELD with REPEAT_CYCLES = 0, no further strobes SHALL occur until release and a new press.
REQ-019 Simultaneous push and pop presses SHALL produce both strobes in the same cycle; there is no arbitration in this block.
REQ-020 A strobe SHALL never be high on two consecutive cycles.
REQ-021 The full/empty gating of strobes is out of scope; the downstream FIFO stage applies it.

Reset
REQ-022 While rst is high, synchronizers, stable values, and debounce and repeat counters SHALL clear to 0, both FSMs SHALL go to IDLE, and all outputs SHALL be 0 on the following cycle.
REQ-023 Reset mid-debounce SHALL discard partial counts.
REQ-024 A button held through reset release SHALL be treated as a new press and produce one strobe after the full debounce latency.
REQ-025 rst_btn SHALL be debounced like any other bit; this block SHALL NOT feed it back into its own reset.

Structure
REQ-026 A shared package SHALL hold the switch bit-index constants (DATA_LSB=0, PUSH=4, POP=5, RST=6, MODE=7) and the IDLE/HELD state encoding.
REQ-027 One sub-module, debounce_bit, SHALL contain the synchronizer, counter and stable register for one bit; it is instantiated 8 times.
REQ-028 The edge-detect/repeat FSMs SHALL reside in switch_conditioner.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-029 sw_n[4] 1->0 held -> push_pulse high exactly in cycle 7 after the raw edge, then low; REPEAT_CYCLES=0 -> no further pulse.
REQ-030 sw_n[5] low for 3 cycles, then high -> pop_pulse never asserts; stable pop stays 0.
REQ-031 REPEAT_CYCLES=10, push held 35 cycles after the first pulse -> pulses at +0, +10, +20, +30; release -> no more pulses.
REQ-032 sw_n[3:0] bounces 1010/0101 every 2 cycles, then settles at 0011 -> data_out goes to 4'b1100 exactly 6 cycles after settling, with no intermediate value.
REQ-033 Push and pop pressed on the same cycle -> push_pulse and pop_pulse high on the same single cycle.
REQ-034 rst asserted mid-count with push held; rst released -> all outputs 0 during reset; one push_pulse 7 cycles after release.

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
// Shared constants for the switch conditioner: switch bit positions and
// the push/pop button state encoding.
package switch_conditioner_pkg;

  localparam int NUM_SW   = 8;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 4;
  localparam int PUSH     = 4;
  localparam int POP      = 5;
  localparam int RST      = 6;
  localparam int MODE     = 7;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } btn_state_e;

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: invert, 2-flop synchronize, then debounce into a stable level.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // Synchronize, then flip the stable level once the mismatch has persisted
  // for DEBOUNCE_CYCLES consecutive cycles; any match discards the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= ~raw_n;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Debounces the 8 raw switches and turns push/pop into one-cycle strobes,
// with optional auto-repeat while a button is held.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sw_n,
  output logic [3:0]       data_out,
  output logic             push_pulse,
  output logic             pop_pulse,
  output logic             rst_btn,
  output logic             mode
);

  // An interval of 1 would hold the strobe high continuously, so it is
  // stretched to 2 to keep every strobe a single isolated cycle.
  localparam int RPT = (REPEAT_CYCLES == 1) ? 2 : REPEAT_CYCLES;
  localparam int RW  = (RPT > 1) ? $clog2(RPT) : 1;

  logic [NUM_SW-1:0] stable;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_n  (sw_n[g]),
      .stable (stable[g])
    );
  end

  assign data_out = stable[DATA_LSB +: DATA_W];
  assign rst_btn  = stable[RST];
  assign mode     = stable[MODE];

  for (genvar b = 0; b < 2; b++) begin : g_btn
    localparam int IDX = (b == 0) ? PUSH : POP;

    btn_state_e    state_q, state_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          pulse_d, pulse_q;

    // State, repeat counter and registered strobe
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        rpt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rpt_q   <= rpt_d;
        pulse_q <= pulse_d;
      end
    end

    // Follow the debounced level: press enters HELD, release returns to IDLE
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (stable[IDX])  state_d = HELD;
        HELD:    if (!stable[IDX]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Strobe on press, then every RPT cycles while held; never on release
    always_comb begin
      pulse_d = 1'b0;
      rpt_d   = rpt_q;
      case (state_q)
        IDLE: begin
          rpt_d = '0;
          if (stable[IDX]) pulse_d = 1'b1;
        end
        HELD: begin
          if (!stable[IDX]) begin
            rpt_d = '0;
          end else if (RPT > 0) begin
            if (rpt_q == RW'(RPT - 1)) begin
              pulse_d = 1'b1;
              rpt_d   = '0;
            end else begin
              rpt_d = rpt_q + RW'(1);
            end
          end
        end
        default: rpt_d = '0;
      endcase
    end
  end

  assign push_pulse = g_btn[0].pulse_q;
  assign pop_pulse  = g_btn[1].pulse_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench: two DUTs (no repeat / repeat every 10) share the stimulus and are
// compared every cycle against a history-based model, plus literal scenarios.
module tb_switch_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_n;

  logic [3:0] data0, data1;
  logic       push0, pop0, rb0, mode0;
  logic       push1, pop1, rb1, mode1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0)) u_dut_r0 (
    .clk(clk), .rst(rst), .sw_n(sw_n), .data_out(data0),
    .push_pulse(push0), .pop_pulse(pop0), .rst_btn(rb0), .mode(mode0)
  );

  switch_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(10)) u_dut_r10 (
    .clk(clk), .rst(rst), .sw_n(sw_n), .data_out(data1),
    .push_pulse(push1), .pop_pulse(pop1), .rst_btn(rb1), .mode(mode1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] = inverted switches seen at edge k. A bit's stable level flips at
  // edge k when the synchronized samples (two edges late) over the last D
  // edges all disagree with it and no flip/reset happened inside that window.
  logic [7:0] hist [0:8191];
  int         lastflip [8];
  int         press [2];
  logic [7:0] m_st, m_st_prev;
  logic [1:0] m_push, m_pop;      // index: 0 = no repeat, 1 = repeat 10
  logic       mdl_on = 1'b0;
  int         cyc = 1;

  always @(posedge clk) begin
    if (cyc < 8190) begin
      if (rst) begin
        hist[cyc]   = 8'h00;
        hist[cyc-1] = 8'h00;
        m_st        = 8'h00;
        m_st_prev   = 8'h00;
        m_push      = 2'b00;
        m_pop       = 2'b00;
        for (int b = 0; b < 8; b++) lastflip[b] = cyc;
        mdl_on      = 1'b1;
      end else if (mdl_on) begin
        hist[cyc] = ~sw_n;
        for (int bt = 0; bt < 2; bt++) begin
          int  bi;
          bi = bt ? 5 : 4;
          for (int r = 0; r < 2; r++) begin
            int  per;
            logic p;
            per = r ? 10 : 0;
            if (m_st[bi] && !m_st_prev[bi]) p = 1'b1;
            else p = m_st[bi] && per > 0 && ((cyc - press[bt]) % (per > 0 ? per : 1) == 0);
            if (bt == 0) m_push[r] = p; else m_pop[r] = p;
          end
          if (m_st[bi] && !m_st_prev[bi]) press[bt] = cyc;
        end
        m_st_prev = m_st;
        for (int b = 0; b < 8; b++) begin
          if (cyc - lastflip[b] >= D) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = cyc - D - 1; j <= cyc - 2; j++)
              if (hist[j][b] == m_st[b]) all_diff = 1'b0;
            if (all_diff) begin
              m_st[b]     = ~m_st[b];
              lastflip[b] = cyc;
            end
          end
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (mdl_on) begin
      chk("data_r0", data0, m_st[3:0]);
      chk("data_r10", data1, m_st[3:0]);
      chk("rstbtn_r0", rb0, m_st[6]);
      chk("mode_r0", mode0, m_st[7]);
      chk("rstbtn_r10", rb1, m_st[6]);
      chk("mode_r10", mode1, m_st[7]);
      chk("push_r0", push0, m_push[0]);
      chk("pop_r0", pop0, m_pop[0]);
      chk("push_r10", push1, m_push[1]);
      chk("pop_r10", pop1, m_pop[1]);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_r0"}, {data0, push0, pop0, rb0, mode0}, 8'h00);
    chk({nm, "_r10"}, {data1, push1, pop1, rb1, mode1}, 8'h00);
  endtask

  // ---------------- stimulus + literal expectations ----------------
  initial begin
    rst  = 1'b1;
    sw_n = 8'hFF;
    idle(3);
    chk_all_zero("reset_state");
    rst = 1'b0;
    idle(10);

    // Single push press, held: strobe only at edge 7 (repeat DUT also at 17)
    sw_n[4] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("push_once_r0", push0, i == 7);
      chk("push_once_r10", push1, (i == 7) || (i == 17));
    end
    sw_n = 8'hFF;
    idle(12);

    // 3-cycle pop glitch is filtered
    sw_n[5] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk("pop_glitch", {pop0, pop1}, 2'b00);
      if (i == 3) sw_n[5] = 1'b1;
    end
    idle(5);

    // Auto-repeat every 10 while held, nothing after release
    sw_n[4] = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      chk("push_rpt_r10", push1, (i == 7) || (i == 17) || (i == 27) || (i == 37));
      chk("push_rpt_r0", push0, i == 7);
      if (i == 36) sw_n[4] = 1'b1;
    end
    idle(5);

    // Bouncing data nibble, then settle at 0011
    for (int k = 0; k < 8; k++) begin
      sw_n[3:0] = k[0] ? 4'b1010 : 4'b0101;
      idle(2);
    end
    sw_n[3:0] = 4'b0011;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) chk("data_bit3_not_yet", data0[3], 1'b0);
      if (i >= 6) chk("data_settled", data0, 4'b1100);
    end
    sw_n = 8'hFF;
    idle(12);

    // Push and pop together: both strobes on the same single cycle
    sw_n[5:4] = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("both_push", push0, i == 7);
      chk("both_pop", pop0, i == 7);
    end
    sw_n = 8'hFF;
    idle(12);

    // Reset mid-debounce with push held: fresh press after release
    sw_n[4] = 1'b0;
    idle(3);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk_all_zero("in_reset");
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("push_after_rst_r0", push0, i == 7);
      chk("push_after_rst_r10", push1, i == 7);
    end
    sw_n = 8'hFF;
    idle(12);

    // Random phase: toggle bits with random hold times, occasional reset
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        idle($urandom_range(1, 3));
        rst = 1'b0;
      end else begin
        sw_n = sw_n ^ (8'h01 << $urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) sw_n = sw_n ^ (8'h01 << $urandom_range(0, 7));
        idle($urandom_range(1, 12));
      end
    end
    sw_n = 8'hFF;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
